// File: rtl/serial_frame_decoder_if.sv
// Frame output handshake bundle for serial_frame_decoder.
// frm_perr exists only when PARITY_CHK_EN is defined.
interface serial_frame_decoder_if #(
    parameter int unsigned CMD_W  = 8,
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 32
);
    logic              frm_valid;
    logic              frm_ready;
    logic [CMD_W-1:0]  frm_cmd;
    logic [ADDR_W-1:0] frm_addr;
    logic [DATA_W-1:0] frm_data;
`ifdef PARITY_CHK_EN
    logic              frm_perr;
`endif

    modport master (
        input  frm_ready,
        output frm_valid,
        output frm_cmd,
        output frm_addr,
`ifdef PARITY_CHK_EN
        output frm_perr,
`endif
        output frm_data
    );

    modport slave (
        output frm_ready,
        input  frm_valid,
        input  frm_cmd,
        input  frm_addr,
`ifdef PARITY_CHK_EN
        input  frm_perr,
`endif
        input  frm_data
    );
endinterface

// File: rtl/serial_frame_decoder.sv
// Single-lane serial CMD/ADDR/DATA frame decoder with a valid/ready output register.
// Define PARITY_CHK_EN to add a trailing even-parity bit and the frm_perr output.
module serial_frame_decoder #(
    parameter int unsigned CMD_W     = 8,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned DATA_W    = 32,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sin,
    input  logic                   clr_ovf,
    serial_frame_decoder_if.master frm,
    output logic                   ovf,
    output logic                   busy,
    output logic [CNT_W-1:0]       frame_cnt
);
    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StPar} state_e;

    state_e            state_q, state_d;
    logic              sin_q;
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [CMD_W-1:0]  cmd_sr_q, cmd_sr_d, cmd_shift;
    logic [ADDR_W-1:0] addr_sr_q, addr_sr_d, addr_shift;
    logic [DATA_W-1:0] data_sr_q, data_sr_d, data_shift, load_data;
    logic              par_q, par_d;
    logic              sop, last_bit, load, drop;

    logic              valid_q, valid_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // sin_q resets low so a line held low through reset cannot fake a falling edge.
    assign sop = (state_q == StIdle) && sin_q && !sin;

    always_comb begin
        if (MSB_FIRST) begin
            cmd_shift  = (cmd_sr_q << 1) | CMD_W'(sin);
            addr_shift = (addr_sr_q << 1) | ADDR_W'(sin);
            data_shift = (data_sr_q << 1) | DATA_W'(sin);
        end else begin
            cmd_shift  = (cmd_sr_q >> 1) | (CMD_W'(sin) << (CMD_W - 1));
            addr_shift = (addr_sr_q >> 1) | (ADDR_W'(sin) << (ADDR_W - 1));
            data_shift = (data_sr_q >> 1) | (DATA_W'(sin) << (DATA_W - 1));
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_sr_d  = cmd_sr_q;
        addr_sr_d = addr_sr_q;
        data_sr_d = data_sr_q;
        par_d     = par_q;
        last_bit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sop) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                end
            end
            StCmd: begin
                cmd_sr_d = cmd_shift;
                par_d    = par_q ^ sin;
                if (bit_cnt_q == 7'(CMD_W - 1)) begin
                    state_d   = StAddr;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            StAddr: begin
                addr_sr_d = addr_shift;
                par_d     = par_q ^ sin;
                if (bit_cnt_q == 7'(ADDR_W - 1)) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            StData: begin
                data_sr_d = data_shift;
                par_d     = par_q ^ sin;
                if (bit_cnt_q == 7'(DATA_W - 1)) begin
                    bit_cnt_d = '0;
`ifdef PARITY_CHK_EN
                    state_d   = StPar;
`else
                    state_d   = StIdle;
                    last_bit  = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
`ifdef PARITY_CHK_EN
            StPar: begin
                state_d  = StIdle;
                last_bit = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // On the last DATA bit the field register has not yet absorbed that bit.
    assign load_data = (state_q == StData) ? data_shift : data_sr_q;
    assign load      = last_bit && (!valid_q || frm.frm_ready);
    assign drop      = last_bit && !load;

    always_comb begin
        valid_d = valid_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        perr_d  = perr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (load) begin
            valid_d = 1'b1;
            cmd_d   = cmd_sr_q;
            addr_d  = addr_sr_q;
            data_d  = load_data;
            perr_d  = par_q ^ sin;
            cnt_d   = cnt_q + 1'b1;
        end else if (valid_q && frm.frm_ready) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            sin_q     <= 1'b0;
            bit_cnt_q <= '0;
            cmd_sr_q  <= '0;
            addr_sr_q <= '0;
            data_sr_q <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sin_q     <= sin;
            bit_cnt_q <= bit_cnt_d;
            cmd_sr_q  <= cmd_sr_d;
            addr_sr_q <= addr_sr_d;
            data_sr_q <= data_sr_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign frm.frm_valid = valid_q;
    assign frm.frm_cmd   = cmd_q;
    assign frm.frm_addr  = addr_q;
    assign frm.frm_data  = data_q;
`ifdef PARITY_CHK_EN
    assign frm.frm_perr  = perr_q;
`endif
    assign ovf           = ovf_q;
    assign busy          = (state_q != StIdle);
    assign frame_cnt     = cnt_q;
endmodule
